// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, funct fields, ALU/jump/immediate
// encodings and the ID/EX bundle layout.
package decode_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    JUMP_NONE = 2'd0,
    JUMP_JAL  = 2'd1,
    JUMP_JALR = 2'd2
  } jump_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    alu_op_e         alu_op;
    logic            alu_src_imm;
    logic            alu_src_pc;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      mem_funct3;
    logic            reg_write;
    logic            branch;
    jump_e           jump;
    logic            illegal;
  } id_ex_t;

  function automatic logic [XLEN-1:0] gen_imm(input imm_fmt_e fmt, input logic [31:0] ins);
    logic [XLEN-1:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'h000};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = {XLEN{1'b0}};
    endcase
    return imm;
  endfunction

  // alt selects SUB/SRA; callers only raise it where funct7 allows
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SR:      op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      F3_AND:     op = ALU_AND;
      default:    op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_if.sv
// ID/EX bundle as seen by the execute stage; decode drives it as master.
interface decode_if;
  import decode_pkg::*;

  logic            valid;
  logic [XLEN-1:0] pc;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  alu_op_e         alu_op;
  logic            alu_src_imm;
  logic            alu_src_pc;
  logic            mem_read;
  logic            mem_write;
  logic [2:0]      mem_funct3;
  logic            reg_write;
  logic            branch;
  jump_e           jump;
  logic            illegal;

  modport master (
    output valid, pc, rs1, rs2, rd, rs1_data, rs2_data, imm, alu_op,
           alu_src_imm, alu_src_pc, mem_read, mem_write, mem_funct3,
           reg_write, branch, jump, illegal
  );

  modport slave (
    input valid, pc, rs1, rs2, rd, rs1_data, rs2_data, imm, alu_op,
          alu_src_imm, alu_src_pc, mem_read, mem_write, mem_funct3,
          reg_write, branch, jump, illegal
  );

endinterface

// File: rtl/decode_regfile.sv
// 32x32 integer register file: two async read ports, one sync write port,
// x0 hardwired to zero, optional write-first forwarding.
module decode_regfile #(
  parameter int XLEN   = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs_r [32];

  // Register array: clear on reset, writes to x0 dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (we && (wr_addr != 5'd0)) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  // Read port 1
  always_comb begin
    if (rs1_addr == 5'd0) begin
      rs1_data = {XLEN{1'b0}};
    end else if (BYPASS && we && (wr_addr == rs1_addr)) begin
      rs1_data = wr_data;
    end else begin
      rs1_data = regs_r[rs1_addr];
    end
  end

  // Read port 2
  always_comb begin
    if (rs2_addr == 5'd0) begin
      rs2_data = {XLEN{1'b0}};
    end else if (BYPASS && we && (wr_addr == rs2_addr)) begin
      rs2_data = wr_data;
    end else begin
      rs2_data = regs_r[rs2_addr];
    end
  end

endmodule

// File: rtl/decode.sv
// RV32I ID stage: decodes IF/ID, reads the regfile, detects load-use hazards
// and registers the ID/EX bundle with a one-cycle latency.
module decode
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_id__pc,
  input  logic [31:0]     if_id__ins,
  input  logic            pipe_flush,
  input  logic            mb_if__jump_taken,
  input  logic            wb_id__we,
  input  logic [4:0]      wb_id__rd,
  input  logic [XLEN-1:0] wb_id__data,
  output logic            data_hazard,
  decode_if.master        id_ex
);

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [6:0]      funct7_s;
  logic [4:0]      rs1_s, rs2_s, rd_s;
  logic [XLEN-1:0] rs1_data_s, rs2_data_s;
  logic            in_valid_s;

  imm_fmt_e        fmt_s;
  alu_op_e         alu_op_s;
  jump_e           jump_s;
  logic            src_imm_s, src_pc_s, mem_read_s, mem_write_s;
  logic [2:0]      mem_f3_s;
  logic            reg_write_s, branch_s, illegal_s;
  logic            uses_rs1_s, uses_rs2_s;

  id_ex_t          nxt_s;
  id_ex_t          id_ex_r;

  assign opcode_s = if_id__ins[6:0];
  assign rd_s     = if_id__ins[11:7];
  assign funct3_s = if_id__ins[14:12];
  assign rs1_s    = if_id__ins[19:15];
  assign rs2_s    = if_id__ins[24:20];
  assign funct7_s = if_id__ins[31:25];

  decode_regfile #(.XLEN(XLEN), .BYPASS(BYPASS)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_s),
    .rs2_addr (rs2_s),
    .rs1_data (rs1_data_s),
    .rs2_data (rs2_data_s),
    .we       (wb_id__we),
    .wr_addr  (wb_id__rd),
    .wr_data  (wb_id__data)
  );

  // Opcode decoder; illegal gating of the controls happens at bundle assembly
  always_comb begin
    fmt_s       = IMM_NONE;
    alu_op_s    = ALU_ADD;
    jump_s      = JUMP_NONE;
    src_imm_s   = 1'b0;
    src_pc_s    = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    mem_f3_s    = 3'b000;
    reg_write_s = 1'b0;
    branch_s    = 1'b0;
    illegal_s   = 1'b0;
    uses_rs1_s  = 1'b1;
    uses_rs2_s  = 1'b0;
    case (opcode_s)
      OPC_LUI: begin
        fmt_s = IMM_U; alu_op_s = ALU_LUI; src_imm_s = 1'b1;
        reg_write_s = 1'b1; uses_rs1_s = 1'b0;
      end
      OPC_AUIPC: begin
        fmt_s = IMM_U; src_imm_s = 1'b1; src_pc_s = 1'b1;
        reg_write_s = 1'b1; uses_rs1_s = 1'b0;
      end
      OPC_JAL: begin
        fmt_s = IMM_J; jump_s = JUMP_JAL; src_pc_s = 1'b1;
        reg_write_s = 1'b1; uses_rs1_s = 1'b0;
      end
      OPC_JALR: begin
        fmt_s = IMM_I; jump_s = JUMP_JALR; src_pc_s = 1'b1; reg_write_s = 1'b1;
        illegal_s = (funct3_s != 3'b000);
      end
      OPC_BRANCH: begin
        fmt_s = IMM_B; alu_op_s = ALU_SUB; branch_s = 1'b1;
        mem_f3_s = funct3_s; uses_rs2_s = 1'b1;
        illegal_s = (funct3_s == 3'b010) || (funct3_s == 3'b011);
      end
      OPC_LOAD: begin
        fmt_s = IMM_I; src_imm_s = 1'b1; mem_read_s = 1'b1;
        mem_f3_s = funct3_s; reg_write_s = 1'b1;
        illegal_s = !(funct3_s inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      OPC_STORE: begin
        fmt_s = IMM_S; src_imm_s = 1'b1; mem_write_s = 1'b1;
        mem_f3_s = funct3_s; uses_rs2_s = 1'b1;
        illegal_s = !(funct3_s inside {3'b000, 3'b001, 3'b010});
      end
      OPC_OP_IMM: begin
        fmt_s = IMM_I; src_imm_s = 1'b1; reg_write_s = 1'b1;
        alu_op_s = alu_from_f3(funct3_s, (funct3_s == F3_SR) && (funct7_s == F7_ALT));
        illegal_s = ((funct3_s == F3_SLL) && (funct7_s != F7_BASE)) ||
                    ((funct3_s == F3_SR) && (funct7_s != F7_BASE) && (funct7_s != F7_ALT));
      end
      OPC_OP: begin
        reg_write_s = 1'b1; uses_rs2_s = 1'b1;
        alu_op_s = alu_from_f3(funct3_s, funct7_s == F7_ALT);
        illegal_s = !((funct7_s == F7_BASE) ||
                      ((funct7_s == F7_ALT) && ((funct3_s == F3_ADD_SUB) || (funct3_s == F3_SR))));
      end
      OPC_MISC_MEM: begin
        // FENCE has no effect in this in-order pipe
        fmt_s = IMM_NONE;
      end
      OPC_SYSTEM: begin
        fmt_s = IMM_I; illegal_s = 1'b1;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  // Assemble the candidate bundle with illegal and rd=0 gating applied
  always_comb begin
    nxt_s             = '0;
    nxt_s.valid       = 1'b1;
    nxt_s.pc          = if_id__pc;
    nxt_s.rs1         = rs1_s;
    nxt_s.rs2         = rs2_s;
    nxt_s.rd          = rd_s;
    nxt_s.rs1_data    = rs1_data_s;
    nxt_s.rs2_data    = rs2_data_s;
    nxt_s.imm         = gen_imm(fmt_s, if_id__ins);
    nxt_s.alu_op      = alu_op_s;
    nxt_s.alu_src_imm = src_imm_s;
    nxt_s.alu_src_pc  = src_pc_s;
    nxt_s.mem_read    = mem_read_s && !illegal_s;
    nxt_s.mem_write   = mem_write_s && !illegal_s;
    nxt_s.mem_funct3  = mem_f3_s;
    nxt_s.reg_write   = reg_write_s && !illegal_s && (rd_s != 5'd0);
    nxt_s.branch      = branch_s && !illegal_s;
    nxt_s.jump        = illegal_s ? JUMP_NONE : jump_s;
    nxt_s.illegal     = illegal_s;
  end

  assign in_valid_s = !pipe_flush && !mb_if__jump_taken;

  // A load in EX whose rd feeds this instruction stalls it for one cycle
  assign data_hazard = !rst && in_valid_s && id_ex_r.valid && id_ex_r.mem_read &&
                       (id_ex_r.rd != 5'd0) &&
                       ((uses_rs1_s && (rs1_s == id_ex_r.rd)) ||
                        (uses_rs2_s && (rs2_s == id_ex_r.rd)));

  // ID/EX register: reset, squash and stall all load a bubble
  always_ff @(posedge clk) begin
    if (rst || !in_valid_s || data_hazard) begin
      id_ex_r <= '0;
    end else begin
      id_ex_r <= nxt_s;
    end
  end

  assign id_ex.valid       = id_ex_r.valid;
  assign id_ex.pc          = id_ex_r.pc;
  assign id_ex.rs1         = id_ex_r.rs1;
  assign id_ex.rs2         = id_ex_r.rs2;
  assign id_ex.rd          = id_ex_r.rd;
  assign id_ex.rs1_data    = id_ex_r.rs1_data;
  assign id_ex.rs2_data    = id_ex_r.rs2_data;
  assign id_ex.imm         = id_ex_r.imm;
  assign id_ex.alu_op      = id_ex_r.alu_op;
  assign id_ex.alu_src_imm = id_ex_r.alu_src_imm;
  assign id_ex.alu_src_pc  = id_ex_r.alu_src_pc;
  assign id_ex.mem_read    = id_ex_r.mem_read;
  assign id_ex.mem_write   = id_ex_r.mem_write;
  assign id_ex.mem_funct3  = id_ex_r.mem_funct3;
  assign id_ex.reg_write   = id_ex_r.reg_write;
  assign id_ex.branch      = id_ex_r.branch;
  assign id_ex.jump        = id_ex_r.jump;
  assign id_ex.illegal     = id_ex_r.illegal;

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: stimulus pushes hand-computed bundles into a
// queue, a negedge monitor pops and compares each valid ID/EX bundle.
module tb_decode;
  import decode_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic        reg_write;
    logic        branch;
    logic [1:0]  jump;
    logic        illegal;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] if_id__pc;
  logic [31:0] if_id__ins;
  logic        pipe_flush;
  logic        mb_if__jump_taken;
  logic        wb_id__we;
  logic [4:0]  wb_id__rd;
  logic [31:0] wb_id__data;
  logic        data_hazard;

  decode_if id_ex ();

  decode #(.XLEN(32), .BYPASS(1'b1)) dut (
    .clk               (clk),
    .rst               (rst),
    .if_id__pc         (if_id__pc),
    .if_id__ins        (if_id__ins),
    .pipe_flush        (pipe_flush),
    .mb_if__jump_taken (mb_if__jump_taken),
    .wb_id__we         (wb_id__we),
    .wb_id__rd         (wb_id__rd),
    .wb_id__data       (wb_id__data),
    .data_hazard       (data_hazard),
    .id_ex             (id_ex)
  );

  int    total = 0;
  int    bad   = 0;
  exp_t  exp_q[$];
  string name_q[$];
  exp_t  act_m;
  exp_t  exp_m;
  string name_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(
    input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
    input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm, input logic [3:0] op,
    input logic simm, input logic spc, input logic mr, input logic mw, input logic [2:0] f3,
    input logic rw, input logic br, input logic [1:0] jmp, input logic ill);
    exp_t e;
    e = {pc, rs1, rs2, rd, d1, d2, imm, op, simm, spc, mr, mw, f3, rw, br, jmp, ill};
    return e;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction that must issue; hazard must be low while it sits in ID
  task automatic issue(input string n, input logic [31:0] pc, input logic [31:0] ins, input exp_t e);
    if_id__pc  = pc;
    if_id__ins = ins;
    #1;
    chk({"hz_", n}, 32'(data_hazard), 32'd0);
    exp_q.push_back(e);
    name_q.push_back(n);
    tick();
  endtask

  // Monitor: every valid bundle must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (id_ex.valid === 1'b1) begin
      total++;
      act_m = {id_ex.pc, id_ex.rs1, id_ex.rs2, id_ex.rd, id_ex.rs1_data, id_ex.rs2_data,
               id_ex.imm, id_ex.alu_op, id_ex.alu_src_imm, id_ex.alu_src_pc, id_ex.mem_read,
               id_ex.mem_write, id_ex.mem_funct3, id_ex.reg_write, id_ex.branch, id_ex.jump,
               id_ex.illegal};
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_bundle: got pc=%h want no valid bundle", id_ex.pc);
      end else begin
        exp_m  = exp_q.pop_front();
        name_m = name_q.pop_front();
        if (act_m !== exp_m) begin
          bad++;
          $display("FAIL %s: got %h want %h", name_m, act_m, exp_m);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; pipe_flush = 1'b0; mb_if__jump_taken = 1'b0;
    wb_id__we = 1'b0; wb_id__rd = 5'd0; wb_id__data = 32'd0;
    if_id__pc = 32'd0; if_id__ins = 32'h0000_0013;

    // reset for two cycles, then one flush cycle with a load in IF/ID
    tick();
    chk("rst_valid0", 32'(id_ex.valid), 32'd0);
    chk("rst_hz0", 32'(data_hazard), 32'd0);
    tick();
    chk("rst_valid1", 32'(id_ex.valid), 32'd0);
    rst = 1'b0; pipe_flush = 1'b1; if_id__ins = 32'h0000_A103;
    #1;
    chk("flush_hz", 32'(data_hazard), 32'd0);
    tick();
    chk("flush_valid", 32'(id_ex.valid), 32'd0);
    pipe_flush = 1'b0;

    issue("addi", 32'h10, 32'h0050_0093,
          mk(32'h10, 5'd0, 5'd5, 5'd1, 32'd0, 32'd0, 32'd5, ALU_ADD,
             1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0));

    // load-use: one stall cycle, one bubble, then the add
    issue("lw", 32'h14, 32'h0000_A103,
          mk(32'h14, 5'd1, 5'd0, 5'd2, 32'd0, 32'd0, 32'd0, ALU_ADD,
             1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 2'd0, 1'b0));
    if_id__pc = 32'h18; if_id__ins = 32'h0021_01B3;
    #1;
    chk("lu_hz1", 32'(data_hazard), 32'd1);
    tick();
    chk("lu_bubble", 32'(id_ex.valid), 32'd0);
    issue("add_after_stall", 32'h18, 32'h0021_01B3,
          mk(32'h18, 5'd2, 5'd2, 5'd3, 32'd0, 32'd0, 32'd0, ALU_SUB - ALU_SUB + ALU_ADD,
             1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0));

    // load-use with a redirect on the hazard cycle: jump wins
    issue("lw2", 32'h20, 32'h0000_A103,
          mk(32'h20, 5'd1, 5'd0, 5'd2, 32'd0, 32'd0, 32'd0, ALU_ADD,
             1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 2'd0, 1'b0));
    if_id__pc = 32'h24; if_id__ins = 32'h0021_01B3; mb_if__jump_taken = 1'b1;
    #1;
    chk("jump_hz", 32'(data_hazard), 32'd0);
    tick();
    chk("jump_bubble", 32'(id_ex.valid), 32'd0);
    mb_if__jump_taken = 1'b0;

    // same-cycle WB forwarding, x0 write ignored, write persists
    wb_id__we = 1'b1; wb_id__rd = 5'd5; wb_id__data = 32'hDEAD_BEEF;
    issue("wb_bypass", 32'h28, 32'h0002_8333,
          mk(32'h28, 5'd5, 5'd0, 5'd6, 32'hDEAD_BEEF, 32'd0, 32'd0, ALU_ADD,
             1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0));
    wb_id__rd = 5'd0; wb_id__data = 32'h1234_5678;
    issue("x0_write", 32'h2C, 32'h0000_03B3,
          mk(32'h2C, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'd0, ALU_ADD,
             1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0));
    wb_id__we = 1'b0;
    issue("x5_readback", 32'h30, 32'h0050_0433,
          mk(32'h30, 5'd0, 5'd5, 5'd8, 32'd0, 32'hDEAD_BEEF, 32'd0, ALU_ADD,
             1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0));

    issue("beq", 32'h34, 32'hFE00_0EE3,
          mk(32'h34, 5'd0, 5'd0, 5'h1D, 32'd0, 32'd0, 32'hFFFF_FFFC, ALU_SUB,
             1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 2'd0, 1'b0));
    issue("ecall", 32'h38, 32'h0000_0073,
          mk(32'h38, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, ALU_ADD,
             1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1));
    issue("fence", 32'h3C, 32'h0000_000F,
          mk(32'h3C, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, ALU_ADD,
             1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0));
    issue("lui", 32'h40, 32'h1234_54B7,
          mk(32'h40, 5'd8, 5'd3, 5'd9, 32'd0, 32'd0, 32'h1234_5000, ALU_LUI,
             1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0));
    issue("nop_rd0", 32'h44, 32'h0000_0013,
          mk(32'h44, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, ALU_ADD,
             1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0));

    // reset in the middle of a stall: hazard drops at once, bundle and regfile clear
    issue("lw3", 32'h48, 32'h0000_A103,
          mk(32'h48, 5'd1, 5'd0, 5'd2, 32'd0, 32'd0, 32'd0, ALU_ADD,
             1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 2'd0, 1'b0));
    if_id__pc = 32'h4C; if_id__ins = 32'h0021_01B3;
    #1;
    chk("stall_hz", 32'(data_hazard), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_stall_hz", 32'(data_hazard), 32'd0);
    tick();
    chk("rst_stall_valid", 32'(id_ex.valid), 32'd0);
    rst = 1'b0;
    issue("x5_cleared", 32'h50, 32'h0050_0433,
          mk(32'h50, 5'd0, 5'd5, 5'd8, 32'd0, 32'd0, 32'd0, ALU_ADD,
             1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0));

    pipe_flush = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() != 0) tick();
    end
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
